cla_subtractor_pipe: RTL
========================

CLA_SUBTRACTOR_PIPE -- requirements
Module: cla_subtractor_pipe

Interface
REQ-001 Parameter: WIDTH, default 10, operand width; SHALL be even and >= 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: a  input  WIDTH  minuend.
REQ-005 Port: b  input  WIDTH  subtrahend.
REQ-006 Port: bin  input  1  borrow in.
REQ-007 Port: in_valid  input  1  a/b/bin valid this cycle.
REQ-008 Port: in_ready  output  1  block accepts operands this cycle.
REQ-009 Port: d  output  WIDTH  difference (a - b - bin) mod 2^WIDTH.
REQ-010 Port: bout  output  1  borrow out; 1 when a < b + bin, unsigned.
REQ-011 Port: out_valid  output  1  d/bout valid.
REQ-012 Port: out_ready  input  1  downstream accepts result.

Function
REQ-013 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-014 Two pipeline stages; stage 1 registers low WIDTH/2 difference bits, their borrow, and the high operand halves; stage 2 computes the high half using the registered borrow.
REQ-015 Latency SHALL be exactly 2 cycles from input transfer to out_valid, with out_ready held high.
REQ-016 Throughput SHALL be one operation per cycle while out_ready is high.
REQ-017 Each half SHALL use borrow-lookahead: generate = ~x & y, propagate = ~(x ^ y), borrow[i+1] = gen[i] | (prop[i] & borrow[i]).
REQ-018 in_ready SHALL equal !s1_valid || !s2_valid || out_ready; no combinational path from in_valid to in_ready.
REQ-019 Stage 2 SHALL hold d, bout, and out_valid stable while out_valid && !out_ready.
REQ-020 With stage 2 stalled and stage 1 full, in_ready SHALL be 0 and stage 1 SHALL hold.
REQ-021 If output transfer and input transfer occur in the same cycle, both SHALL complete with no bubble and no loss.
REQ-022 Results SHALL leave in acceptance order.
REQ-023 No operand or result is dropped or duplicated under any in_valid/out_ready pattern.
REQ-024 Wrap-around: d SHALL be modulo 2^WIDTH; bout carries the underflow.

Reset
REQ-025 When rst_n is low, s1_valid and s2_valid SHALL clear asynchronously, giving out_valid=0 and in_ready=1 as the stages empty.
REQ-026 d and bout SHALL reset to 0.
REQ-027 Reset mid-operation SHALL discard all in-flight operations; the first result after reset comes from the first post-reset input transfer.
REQ-028 Reset release SHALL be synchronised externally; the block only samples inputs on clk edges after rst_n is high.

Configuration
REQ-029 Macro CLA_SUB_OVF_EN: when defined, add output port ovf (output, 1 bit), registered with d, set to 1 when the two's-complement subtraction overflows: (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]), with bin included in d.
REQ-030 When ovf is present, it SHALL reset to 0 and obey the same hold rules as d.
REQ-031 Without CLA_SUB_OVF_EN, there SHALL be no ovf port and no overflow logic.

Structure
REQ-032 A shared package cla_pkg SHALL hold the default width constant CLA_WIDTH=10 and a struct type for the stage-1 payload: low difference, borrow, high a, high b, sign bits.
REQ-033 Each half SHALL be an instance of sub-module cla_sub_slice, parameter W, inputs x, y, bi, outputs d, bo; purely combinational.

Verification
REQ-034 Basic: a=10'd5, b=10'd3, bin=0, out_ready=1 -> two cycles later d=10'd2, bout=0.
REQ-035 Underflow: a=0, b=1, bin=0 -> d=10'h3FF, bout=1. With bin=1 and a=b=10'h155 -> d=10'h3FF, bout=1.
REQ-036 Back-pressure: stream 8 random operands with out_ready low for cycles 3-6 -> in_ready=0 once both stages are full, d held stable, and all 8 results in order, matching the reference model.
REQ-037 Reset mid-flight: apply rst_n low with 2 operations in flight -> out_valid=0 immediately; after release, next result corresponds to the first new operand.
REQ-038 Overflow (CLA_SUB_OVF_EN): a=10'h200 (-512), b=10'h001 -> d=10'h1FF, ovf=1; a=10'h001, b=10'h002 -> ovf=0.
REQ-039 Exhaustive/random: 10^5 random (a, b, bin) with random out_ready -> every {bout, d} equals {1'b0, a} - b - bin as a (WIDTH+1)-bit value.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and the stage-1 payload type for the pipelined borrow-lookahead subtractor.
// The sign fields exist only when CLA_SUB_OVF_EN is defined.
package cla_pkg;

    localparam int CLA_WIDTH = 10;
    localparam int CLA_HALF  = CLA_WIDTH / 2;

    // Field widths set the widest supported operand: WIDTH may be any even value from 4 up to CLA_WIDTH.
    typedef struct packed {
        logic [CLA_HALF-1:0] loDiff;
        logic                borrow;
        logic [CLA_HALF-1:0] hiA;
        logic [CLA_HALF-1:0] hiB;
`ifdef CLA_SUB_OVF_EN
        logic                signA;
        logic                signB;
`endif
    } s1_payload_t;

endpackage

// File: rtl/cla_sub_slice.sv
// Combinational borrow-lookahead subtractor slice: d = x - y - bi (mod 2^W), bo = borrow out.
module cla_sub_slice #(
    parameter int W = 5
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    logic [W-1:0] gen;
    logic [W-1:0] prop;
    logic [W:0]   borrow;
    logic         groupBorrow;
    logic         groupProp;

    assign gen  = ~x & y;
    assign prop = ~(x ^ y);

    // Every borrow is expanded directly over the lower bits rather than rippled from its neighbour.
    always_comb begin
        borrow      = '0;
        groupBorrow = 1'b0;
        groupProp   = 1'b0;
        borrow[0]   = bi;
        for (int i = 0; i < W; i++) begin
            groupBorrow = gen[i];
            groupProp   = prop[i];
            for (int j = i - 1; j >= 0; j--) begin
                groupBorrow = groupBorrow | (groupProp & gen[j]);
                groupProp   = groupProp & prop[j];
            end
            borrow[i+1] = groupBorrow | (groupProp & bi);
        end
    end

    assign d  = x ^ y ^ borrow[W-1:0];
    assign bo = borrow[W];

endmodule

// File: rtl/cla_subtractor_pipe.sv
// Two-stage pipelined borrow-lookahead subtractor with valid/ready handshakes on both sides.
// Defining CLA_SUB_OVF_EN adds the registered two's-complement overflow output ovf.
module cla_subtractor_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef CLA_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int HALF = WIDTH / 2;

    logic             s1Valid_q;
    logic             s1Valid_d;
    logic             s2Valid_q;
    logic             s2Valid_d;
    s1_payload_t      s1Payload_q;
    s1_payload_t      s1Payload_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic             bout_q;
    logic             bout_d;
`ifdef CLA_SUB_OVF_EN
    logic             ovf_q;
    logic             ovf_d;
`endif

    logic             s2Free;
    logic             s2Load;
    logic             inFire;
    logic [HALF-1:0]  loDiff;
    logic             loBorrow;
    logic [HALF-1:0]  hiDiff;
    logic             hiBorrow;

    // Stage 2 can take new data when empty or draining; stage 1 when empty or moving into stage 2.
    assign s2Free   = !s2Valid_q || out_ready;
    assign in_ready = !s1Valid_q || s2Free;
    assign inFire   = in_valid && in_ready;
    assign s2Load   = s1Valid_q && s2Free;

    cla_sub_slice #(
        .W (HALF)
    ) u_loSlice (
        .x  (a[HALF-1:0]),
        .y  (b[HALF-1:0]),
        .bi (bin),
        .d  (loDiff),
        .bo (loBorrow)
    );

    cla_sub_slice #(
        .W (HALF)
    ) u_hiSlice (
        .x  (s1Payload_q.hiA[HALF-1:0]),
        .y  (s1Payload_q.hiB[HALF-1:0]),
        .bi (s1Payload_q.borrow),
        .d  (hiDiff),
        .bo (hiBorrow)
    );

    always_comb begin
        s1Valid_d   = s1Valid_q;
        s1Payload_d = s1Payload_q;
        if (inFire) begin
            s1Valid_d                    = 1'b1;
            s1Payload_d                  = '0;
            s1Payload_d.loDiff[HALF-1:0] = loDiff;
            s1Payload_d.borrow           = loBorrow;
            s1Payload_d.hiA[HALF-1:0]    = a[WIDTH-1:HALF];
            s1Payload_d.hiB[HALF-1:0]    = b[WIDTH-1:HALF];
`ifdef CLA_SUB_OVF_EN
            s1Payload_d.signA            = a[WIDTH-1];
            s1Payload_d.signB            = b[WIDTH-1];
`endif
        end else if (s2Free) begin
            s1Valid_d = 1'b0;
        end
    end

    always_comb begin
        s2Valid_d = s2Valid_q;
        d_d       = d_q;
        bout_d    = bout_q;
`ifdef CLA_SUB_OVF_EN
        ovf_d     = ovf_q;
`endif
        if (s2Free) begin
            s2Valid_d = s1Valid_q;
        end
        if (s2Load) begin
            d_d    = {hiDiff, s1Payload_q.loDiff[HALF-1:0]};
            bout_d = hiBorrow;
`ifdef CLA_SUB_OVF_EN
            ovf_d  = (s1Payload_q.signA != s1Payload_q.signB) &&
                     (hiDiff[HALF-1] != s1Payload_q.signA);
`endif
        end
    end

    // Reset drops everything in flight; result registers clear so outputs read 0 until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid_q   <= 1'b0;
            s2Valid_q   <= 1'b0;
            s1Payload_q <= '0;
            d_q         <= '0;
            bout_q      <= 1'b0;
`ifdef CLA_SUB_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            s1Valid_q   <= s1Valid_d;
            s2Valid_q   <= s2Valid_d;
            s1Payload_q <= s1Payload_d;
            d_q         <= d_d;
            bout_q      <= bout_d;
`ifdef CLA_SUB_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign out_valid = s2Valid_q;
`ifdef CLA_SUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule
